// File: rtl/srt_div_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : srt_div_request_sequencer
// Brief    : Request/response sequencer around the 8-bit SRT radix-4 divider
//            core: sign handling, core start pulse, fixed-latency wait.
// Revision : 1.0 - initial release
// ============================================================================
module srt_div_request_sequencer #(
   parameter int DATA_WIDTH  = 8,
   parameter int DIV_LATENCY = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_signed,
   input  logic [DATA_WIDTH-1:0] req_dividend,
   input  logic [DATA_WIDTH-1:0] req_divisor,
   output logic                  div_enable_out,
   output logic [DATA_WIDTH-1:0] div_dividend,
   output logic [DATA_WIDTH-1:0] div_divisor,
   input  logic                  div_ov_flag,
   input  logic [DATA_WIDTH-1:0] div_quotient,
   input  logic [DATA_WIDTH-1:0] div_remainder,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_quotient,
   output logic [DATA_WIDTH-1:0] rsp_remainder,
   output logic                  rsp_div_by_zero
);

   localparam int                CNT_W      = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
   localparam logic [CNT_W-1:0]  C_CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_dividend;
   logic [DATA_WIDTH-1:0] r_mag_dividend;
   logic [DATA_WIDTH-1:0] r_mag_divisor;
   logic                  r_sign_dividend;
   logic                  r_sign_divisor;
   logic [DATA_WIDTH-1:0] r_rsp_quotient;
   logic [DATA_WIDTH-1:0] r_rsp_remainder;
   logic                  r_rsp_div_by_zero;

   logic                  w_accept;
   logic                  w_divisor_zero;
   logic                  w_sign_dividend;
   logic                  w_sign_divisor;
   logic [DATA_WIDTH-1:0] w_fix_quotient;
   logic [DATA_WIDTH-1:0] w_fix_remainder;

   assign w_accept        = req_valid && req_ready;
   assign w_divisor_zero  = (req_divisor == '0);
   assign w_sign_dividend = req_signed && req_dividend[DATA_WIDTH-1];
   assign w_sign_divisor  = req_signed && req_divisor[DATA_WIDTH-1];

   // Negating 0x80 yields 0x80, which is exactly the unsigned magnitude 128.
   assign w_fix_quotient  = (r_sign_dividend ^ r_sign_divisor) ? -div_quotient : div_quotient;
   assign w_fix_remainder = r_sign_dividend ? -div_remainder : div_remainder;

   assign div_dividend    = r_mag_dividend;
   assign div_divisor     = r_mag_divisor;
   assign rsp_quotient    = r_rsp_quotient;
   assign rsp_remainder   = r_rsp_remainder;
   assign rsp_div_by_zero = r_rsp_div_by_zero;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      // Gated by reset_n so req_ready reads 0 while reset is held.
      req_ready      = 1'b0;
      div_enable_out = 1'b0;
      rsp_valid      = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = reset_n;
            if (w_accept) begin
               w_next_state = w_divisor_zero ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            div_enable_out = 1'b1;
            w_next_state   = S_WAIT;
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_next_state = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt             <= '0;
         r_dividend        <= '0;
         r_mag_dividend    <= '0;
         r_mag_divisor     <= '0;
         r_sign_dividend   <= 1'b0;
         r_sign_divisor    <= 1'b0;
         r_rsp_quotient    <= '0;
         r_rsp_remainder   <= '0;
         r_rsp_div_by_zero <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_accept) begin
            r_dividend      <= req_dividend;
            r_sign_dividend <= w_sign_dividend;
            r_sign_divisor  <= w_sign_divisor;
            r_mag_dividend  <= w_sign_dividend ? -req_dividend : req_dividend;
            r_mag_divisor   <= w_sign_divisor ? -req_divisor : req_divisor;
            if (w_divisor_zero) begin
               r_rsp_quotient    <= '1;
               r_rsp_remainder   <= req_dividend;
               r_rsp_div_by_zero <= 1'b1;
            end
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= C_CNT_LOAD;
         end
         if (r_state == S_WAIT) begin
            if (r_cnt == '0) begin
               // A core overflow is reported the same way as a zero divisor.
               if (div_ov_flag) begin
                  r_rsp_quotient    <= '1;
                  r_rsp_remainder   <= r_dividend;
                  r_rsp_div_by_zero <= 1'b1;
               end else begin
                  r_rsp_quotient    <= w_fix_quotient;
                  r_rsp_remainder   <= w_fix_remainder;
                  r_rsp_div_by_zero <= 1'b0;
               end
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
